// File: rtl/mem_access_unit.sv
// Load/store execution unit: one-hot op decode, byte-lane alignment and strobes,
// and a request/response handshake on a word-addressed data-memory bus.
//
//   state   | meaning
//   IDLE    | ready for a new op
//   REQ     | request on the bus, waiting for mem_req_ready
//   WAIT_RD | load issued, waiting for read data (optional timeout)
//   DONE    | one-cycle completion pulse on res_valid
module mem_access_unit #(
   parameter int unsigned TIMEOUT = 0
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_op_valid,
   output logic        o_op_ready,
   input  logic [11:0] i_op_src,
   input  logic [31:0] i_op_addr,
   input  logic [31:0] i_op_rt,
   output logic        o_mem_req,
   output logic        o_mem_we,
   output logic [31:0] o_mem_addr,
   output logic [31:0] o_mem_wdata,
   output logic [3:0]  o_mem_strb,
   input  logic        i_mem_req_ready,
   input  logic [31:0] i_mem_rdata,
   input  logic        i_mem_rdata_vld,
   output logic        o_res_valid,
   output logic [31:0] o_res_data,
   output logic        o_res_err
);

   localparam int B_LW  = 0;
   localparam int B_LB  = 1;
   localparam int B_LBU = 2;
   localparam int B_LH  = 3;
   localparam int B_LHU = 4;
   localparam int B_LWL = 5;
   localparam int B_LWR = 6;
   localparam int B_SW  = 7;
   localparam int B_SB  = 8;
   localparam int B_SH  = 9;
   localparam int B_SWL = 10;
   localparam int B_SWR = 11;

   localparam logic [31:0] L_TO_LAST = 32'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      REQ     = 2'd1,
      WAIT_RD = 2'd2,
      DONE    = 2'd3
   } state_t;

   state_t      r_state;
   logic [6:0]  r_ld_src;
   logic [1:0]  r_a;
   logic [31:0] r_rt;
   logic        r_is_store;
   logic [31:0] r_cnt;

   logic [1:0]  w_a;
   logic        w_onehot;
   logic        w_bad;
   logic        w_is_store;
   logic [3:0]  w_strb;
   logic [31:0] w_wdata;

   function automatic logic [31:0] f_load(input logic [6:0] src, input logic [1:0] a,
                                          input logic [31:0] d, input logic [31:0] rt);
      logic [7:0]  b;
      logic [15:0] h;
      logic [31:0] res;
      b   = 8'(d >> {a, 3'b000});
      h   = 16'(d >> {a[1], 4'b0000});
      res = '0;
      if (src[B_LW])  res = d;
      if (src[B_LB])  res = {{24{b[7]}}, b};
      if (src[B_LBU]) res = {24'd0, b};
      if (src[B_LH])  res = {{16{h[15]}}, h};
      if (src[B_LHU]) res = {16'd0, h};
      // Unaligned partial-word loads keep the rt bytes the loaded bytes do not cover.
      if (src[B_LWL]) res = (d << {~a, 3'b000}) | (rt & ~(32'hFFFF_FFFF << {~a, 3'b000}));
      if (src[B_LWR]) res = (d >> {a, 3'b000})  | (rt & ~(32'hFFFF_FFFF >> {a, 3'b000}));
      return res;
   endfunction

   assign w_a        = i_op_addr[1:0];
   assign w_onehot   = (i_op_src != 12'd0) && ((i_op_src & (i_op_src - 12'd1)) == 12'd0);
   assign w_is_store = |i_op_src[11:7];
   assign w_bad      = !w_onehot
                       || ((i_op_src[B_LW] || i_op_src[B_SW]) && (w_a != 2'd0))
                       || ((i_op_src[B_LH] || i_op_src[B_LHU] || i_op_src[B_SH]) && w_a[0]);

   always_comb begin
      w_strb  = 4'b0000;
      w_wdata = 32'd0;
      if (i_op_src[B_SW]) begin
         w_strb  = 4'b1111;
         w_wdata = i_op_rt;
      end
      if (i_op_src[B_SB]) begin
         w_strb  = 4'b0001 << w_a;
         w_wdata = {4{i_op_rt[7:0]}};
      end
      if (i_op_src[B_SH]) begin
         w_strb  = 4'b0011 << w_a;
         w_wdata = {2{i_op_rt[15:0]}};
      end
      if (i_op_src[B_SWL]) begin
         w_strb  = 4'b1111 >> ~w_a;
         w_wdata = i_op_rt >> {~w_a, 3'b000};
      end
      if (i_op_src[B_SWR]) begin
         w_strb  = 4'b1111 << w_a;
         w_wdata = i_op_rt << {w_a, 3'b000};
      end
   end

   assign o_op_ready = (r_state == IDLE) && !i_rst;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state     <= IDLE;
         r_ld_src    <= '0;
         r_a         <= '0;
         r_rt        <= '0;
         r_is_store  <= 1'b0;
         r_cnt       <= '0;
         o_mem_req   <= 1'b0;
         o_mem_we    <= 1'b0;
         o_mem_addr  <= '0;
         o_mem_wdata <= '0;
         o_mem_strb  <= 4'b0000;
         o_res_valid <= 1'b0;
         o_res_data  <= '0;
         o_res_err   <= 1'b0;
      end else begin
         o_res_valid <= 1'b0;
         case (r_state)
            IDLE: begin
               if (i_op_valid) begin
                  r_ld_src   <= i_op_src[6:0];
                  r_a        <= w_a;
                  r_rt       <= i_op_rt;
                  r_is_store <= w_is_store;
                  if (w_bad) begin
                     r_state     <= DONE;
                     o_res_valid <= 1'b1;
                     o_res_err   <= 1'b1;
                     o_res_data  <= '0;
                  end else begin
                     r_state     <= REQ;
                     o_mem_req   <= 1'b1;
                     o_mem_we    <= w_is_store;
                     o_mem_addr  <= {i_op_addr[31:2], 2'b00};
                     o_mem_wdata <= w_wdata;
                     o_mem_strb  <= w_is_store ? w_strb : 4'b0000;
                  end
               end
            end
            REQ: begin
               if (i_mem_req_ready) begin
                  o_mem_req  <= 1'b0;
                  o_mem_we   <= 1'b0;
                  o_mem_strb <= 4'b0000;
                  if (r_is_store) begin
                     r_state     <= DONE;
                     o_res_valid <= 1'b1;
                     o_res_err   <= 1'b0;
                     o_res_data  <= '0;
                  end else begin
                     r_state <= WAIT_RD;
                     r_cnt   <= '0;
                  end
               end
            end
            WAIT_RD: begin
               // Read data arriving on the last allowed cycle still wins over the timeout.
               if (i_mem_rdata_vld) begin
                  r_state     <= DONE;
                  o_res_valid <= 1'b1;
                  o_res_err   <= 1'b0;
                  o_res_data  <= f_load(r_ld_src, r_a, i_mem_rdata, r_rt);
               end else if ((TIMEOUT != 0) && (r_cnt == L_TO_LAST)) begin
                  r_state     <= DONE;
                  o_res_valid <= 1'b1;
                  o_res_err   <= 1'b1;
                  o_res_data  <= '0;
               end else begin
                  r_cnt <= r_cnt + 32'd1;
               end
            end
            DONE: begin
               r_state <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule
